mem_4k: RTL and testbench

MEM_4K -- requirements
Module: mem_4k

---
 rtl/mem_4k_pkg.sv | 27 ++
 rtl/mem_4k_if.sv | 35 +++
 rtl/mem_4k_lane.sv | 37 +++
 rtl/mem_4k.sv | 108 ++++++++++
 tb/tb_mem_4k.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_4k_pkg.sv
// mem_4k_pkg
//   Shared memory-I/O encodings for the mem_4k bus: transfer direction and
//   port B access width, plus a helper that turns a width code into a byte
//   count.
package mem_4k_pkg;

  // Direction encoding for A_EnWR / B_EnWR
  localparam logic MM_ENB_R = 1'b0;
  localparam logic MM_ENB_W = 1'b1;

  // Port B access width encoding for B_Size
  localparam logic [1:0] MM_BYTE = 2'd0;
  localparam logic [1:0] MM_HALF = 2'd1;
  localparam logic [1:0] MM_WORD = 2'd2;

  // Number of bytes touched by a port B access. Code 3 is treated as a word.
  function automatic logic [2:0] mm_size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      MM_BYTE: n = 3'd1;
      MM_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_4k_if.sv
// mem_4k_if
//   Dual-port memory bus bundle.
//   Port A: word-only access (A_EnWR, A_ABus, A_DBusW in; A_DBusR out).
//   Port B: byte/half/word access (B_EnWR, B_Size, B_ABus, B_DBusW in;
//           B_DBusR out, LSB-aligned).
//   master: the requester side; slave: the memory side.
interface mem_4k_if;
  import mem_4k_pkg::*;

  logic        A_EnWR;
  logic [31:0] A_ABus;
  logic [31:0] A_DBusW;
  logic [31:0] A_DBusR;

  logic        B_EnWR;
  logic [1:0]  B_Size;
  logic [31:0] B_ABus;
  logic [31:0] B_DBusW;
  logic [31:0] B_DBusR;

  modport master (
    output A_EnWR, A_ABus, A_DBusW,
    input  A_DBusR,
    output B_EnWR, B_Size, B_ABus, B_DBusW,
    input  B_DBusR
  );

  modport slave (
    input  A_EnWR, A_ABus, A_DBusW,
    output A_DBusR,
    input  B_EnWR, B_Size, B_ABus, B_DBusW,
    output B_DBusR
  );

endinterface

// File: rtl/mem_4k_lane.sv
// mem_4k_lane
//   One byte lane of the memory: DEPTH bytes with two independent ports.
//   Ports:
//     clk               clock, writes on posedge
//     a_we/a_row/a_wdata  port A write enable, row index, write byte
//     b_we/b_row/b_wdata  port B write enable, row index, write byte
//     a_rdata/b_rdata     combinational read of the addressed row (pre-edge
//                         contents, so the registered read in the top
//                         returns old data on a same-edge write)
//   When both ports write the same row on one edge, port B wins.
module mem_4k_lane #(
  parameter int DEPTH = 1024,
  parameter int ROWW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            a_we,
  input  logic [ROWW-1:0] a_row,
  input  logic [7:0]      a_wdata,
  input  logic            b_we,
  input  logic [ROWW-1:0] b_row,
  input  logic [7:0]      b_wdata,
  output logic [7:0]      a_rdata,
  output logic [7:0]      b_rdata
);

  logic [7:0] mem_q [DEPTH];

  // Port B is written last so it takes precedence on a row collision.
  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_row] <= a_wdata;
    if (b_we) mem_q[b_row] <= b_wdata;
  end

  assign a_rdata = mem_q[a_row];
  assign b_rdata = mem_q[b_row];

endmodule

// File: rtl/mem_4k.sv
// mem_4k
//   MEM_BYTES-byte little-endian dual-port memory built from four byte lanes.
//   Port A accesses aligned words; port B accesses 1/2/4 bytes at any byte
//   address, wrapping modulo MEM_BYTES. Read data is registered (latency 1,
//   read-old on same-edge writes). rst only clears the read registers; the
//   storage keeps accepting writes during reset so code can be preloaded.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset of A_DBusR/B_DBusR
//     bus   mem_4k_if.slave carrying both ports
module mem_4k
  import mem_4k_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic clk,
  input  logic rst,
  mem_4k_if.slave bus
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int DEPTH = MEM_BYTES / 4;
  localparam int ROWW  = AW - 2;

  logic            a_we;
  logic [ROWW-1:0] a_row;
  logic            b_we;
  logic [AW-1:0]   b_base;
  logic [2:0]      b_nbytes;

  // Per-lane port B signals: b_off is the byte's position within the access
  logic [1:0]      b_off       [4];
  logic [AW-1:0]   b_addr      [4];
  logic            lane_b_we   [4];
  logic [ROWW-1:0] lane_b_row  [4];
  logic [7:0]      lane_b_wdata[4];
  logic [7:0]      lane_a_rdata[4];
  logic [7:0]      lane_b_rdata[4];
  logic [1:0]      b_lane_sel  [4];

  logic [31:0] a_rdata_d, a_rdata_q;
  logic [31:0] b_rdata_d, b_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.A_ABus[31:AW], bus.A_ABus[1:0], bus.B_ABus[31:AW]};

  always_comb begin
    a_we     = (bus.A_EnWR == MM_ENB_W);
    a_row    = bus.A_ABus[AW-1:2];
    b_we     = (bus.B_EnWR == MM_ENB_W);
    b_base   = bus.B_ABus[AW-1:0];
    b_nbytes = mm_size_bytes(bus.B_Size);

    // Lane l holds byte (l - base[1:0]) mod 4 of the port B access; its row
    // comes from the wrapped byte address, so an access crossing a row or
    // the top of memory lands on the next row of the low lanes.
    for (int l = 0; l < 4; l++) begin
      b_off[l]        = 2'(l) - b_base[1:0];
      b_addr[l]       = b_base + AW'(b_off[l]);
      lane_b_row[l]   = b_addr[l][AW-1:2];
      lane_b_we[l]    = b_we && ({1'b0, b_off[l]} < b_nbytes);
      lane_b_wdata[l] = bus.B_DBusW[8*b_off[l] +: 8];
    end

    a_rdata_d = {lane_a_rdata[3], lane_a_rdata[2], lane_a_rdata[1], lane_a_rdata[0]};

    // Byte k of the port B result comes from lane base[1:0]+k; bytes past
    // the access width are zero.
    b_rdata_d = 32'h0;
    for (int k = 0; k < 4; k++) begin
      b_lane_sel[k] = b_base[1:0] + 2'(k);
      if (3'(k) < b_nbytes) begin
        b_rdata_d[8*k +: 8] = lane_b_rdata[b_lane_sel[k]];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_4k_lane #(
      .DEPTH (DEPTH),
      .ROWW  (ROWW)
    ) u_lane (
      .clk     (clk),
      .a_we    (a_we),
      .a_row   (a_row),
      .a_wdata (bus.A_DBusW[8*g +: 8]),
      .b_we    (lane_b_we[g]),
      .b_row   (lane_b_row[g]),
      .b_wdata (lane_b_wdata[g]),
      .a_rdata (lane_a_rdata[g]),
      .b_rdata (lane_b_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign bus.A_DBusR = a_rdata_q;
  assign bus.B_DBusR = b_rdata_q;

endmodule

// File: tb/tb_mem_4k.sv
module tb_mem_4k;
  import mem_4k_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_4k_if bus ();

  mem_4k u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.A_EnWR  = we;
    bus.A_ABus  = addr;
    bus.A_DBusW = data;
  endtask

  task automatic set_b(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data);
    bus.B_EnWR  = we;
    bus.B_Size  = size;
    bus.B_ABus  = addr;
    bus.B_DBusW = data;
  endtask

  // One clock: inputs set beforehand are sampled at this posedge; outputs
  // are inspected 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_a(MM_ENB_R, 32'h0, 32'h0);
    set_b(MM_ENB_R, MM_WORD, 32'h0, 32'h0);
    step();
    check("rst_a", bus.A_DBusR, 32'h0);
    check("rst_b", bus.B_DBusR, 32'h0);

    // Preload under reset through port A
    set_a(MM_ENB_W, 32'h800, 32'h0000_0513);
    step();
    check("preload_a_rdata", bus.A_DBusR, 32'h0);
    set_a(MM_ENB_W, 32'h804, 32'h0000_8067);
    step();
    rst = 1'b0;
    set_a(MM_ENB_R, 32'h800, 32'h0);
    set_b(MM_ENB_R, MM_WORD, 32'h800, 32'h0);
    step();
    check("preload_rd_800", bus.A_DBusR, 32'h0000_0513);
    check("preload_b_800", bus.B_DBusR, 32'h0000_0513);
    set_a(MM_ENB_R, 32'h806, 32'h0);
    step();
    check("preload_rd_804", bus.A_DBusR, 32'h0000_8067);

    // Port B word write then byte / half reads
    set_b(MM_ENB_W, MM_WORD, 32'h100, 32'hAABB_CCDD);
    step();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_b [4];
      exp_b = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
      set_b(MM_ENB_R, MM_BYTE, 32'h100 + 32'(i), 32'hFFFF_FFFF);
      step();
      check($sformatf("b_byte_%0d", i), bus.B_DBusR, exp_b[i]);
    end
    set_b(MM_ENB_R, MM_HALF, 32'h102, 32'h0);
    set_a(MM_ENB_R, 32'h100, 32'h0);
    step();
    check("b_half_102", bus.B_DBusR, 32'h0000_AABB);
    check("a_word_100", bus.A_DBusR, 32'hAABB_CCDD);

    // Unaligned half write, upper write bits must be ignored
    set_b(MM_ENB_W, MM_HALF, 32'h101, 32'hFFFF_1234);
    step();
    set_b(MM_ENB_R, MM_WORD, 32'h100, 32'h0);
    step();
    check("half_merge", bus.B_DBusR, 32'hAA12_34DD);
    set_b(MM_ENB_R, 2'd3, 32'h100, 32'h0);
    step();
    check("size3_word", bus.B_DBusR, 32'hAA12_34DD);

    // Wrap-around word write at the top of memory
    set_b(MM_ENB_W, MM_WORD, 32'hFFE, 32'h1122_3344);
    step();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wa [4];
      logic [31:0] wd [4];
      wa = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
      wd = '{32'h44, 32'h33, 32'h22, 32'h11};
      set_b(MM_ENB_R, MM_BYTE, wa[i], 32'h0);
      step();
      check($sformatf("wrap_byte_%0d", i), bus.B_DBusR, wd[i]);
    end
    set_a(MM_ENB_R, 32'hFFFF_F002, 32'h0);
    set_b(MM_ENB_R, MM_BYTE, 32'h1234_5FFE, 32'h0);
    step();
    check("wrap_a_lowhalf", {16'h0, bus.A_DBusR[15:0]}, 32'h0000_1122);
    check("b_upper_addr_ignored", bus.B_DBusR, 32'h44);
    set_b(MM_ENB_R, MM_HALF, 32'hFFF, 32'h0);
    step();
    check("wrap_half_read", bus.B_DBusR, 32'h0000_2233);

    // Same-edge collision: B wins, reads return old contents
    set_a(MM_ENB_W, 32'h200, 32'h5A5A_5A5A);
    step();
    set_a(MM_ENB_W, 32'h200, 32'h0);
    set_b(MM_ENB_W, MM_WORD, 32'h200, 32'hFFFF_FFFF);
    step();
    check("collide_b_old", bus.B_DBusR, 32'h5A5A_5A5A);
    check("collide_a_old", bus.A_DBusR, 32'h5A5A_5A5A);
    set_a(MM_ENB_R, 32'h200, 32'h0);
    set_b(MM_ENB_R, MM_WORD, 32'h200, 32'h0);
    step();
    check("collide_b_wins", bus.B_DBusR, 32'hFFFF_FFFF);
    check("collide_a_sees_b", bus.A_DBusR, 32'hFFFF_FFFF);

    // Cross-port read-old and a narrow write preserving neighbours
    set_a(MM_ENB_W, 32'h300, 32'hCAFE_BABE);
    step();
    set_a(MM_ENB_W, 32'h300, 32'h0102_0304);
    set_b(MM_ENB_R, MM_BYTE, 32'h300, 32'h0);
    step();
    check("xport_read_old", bus.B_DBusR, 32'h0000_00BE);
    set_a(MM_ENB_R, 32'h300, 32'h0);
    set_b(MM_ENB_W, MM_BYTE, 32'h301, 32'hFFFF_FF77);
    step();
    check("b_write_read_old", bus.B_DBusR, 32'h0000_0003);
    check("a_read_new_300", bus.A_DBusR, 32'h0102_0304);
    set_b(MM_ENB_R, MM_WORD, 32'h300, 32'h0);
    step();
    check("byte_write_merge", bus.A_DBusR, 32'h0102_7704);

    // Reset mid-operation, with a port B preload while in reset
    set_a(MM_ENB_R, 32'h100, 32'h0);
    set_b(MM_ENB_R, MM_WORD, 32'h200, 32'h0);
    step();
    check("pre_rst_a", bus.A_DBusR, 32'hAA12_34DD);
    check("pre_rst_b", bus.B_DBusR, 32'hFFFF_FFFF);
    rst = 1'b1;
    set_b(MM_ENB_W, MM_WORD, 32'h400, 32'h0BAD_F00D);
    step();
    check("mid_rst_a", bus.A_DBusR, 32'h0);
    check("mid_rst_b", bus.B_DBusR, 32'h0);
    rst = 1'b0;
    set_b(MM_ENB_R, MM_WORD, 32'h200, 32'h0);
    step();
    check("post_rst_a", bus.A_DBusR, 32'hAA12_34DD);
    check("post_rst_b", bus.B_DBusR, 32'hFFFF_FFFF);
    set_a(MM_ENB_R, 32'h400, 32'h0);
    step();
    check("rst_preload_b", bus.A_DBusR, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
